// File: rtl/line_engine_feeder.sv
// Responder for the line conv2d engine: serves per-pixel activation reads and
// weight-refill bursts from the on-chip BRAMs and tracks line completion.
module line_engine_feeder #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int REG_WIDTH   = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_data_req,
  input  logic                                      i_data_end,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0]          o_data,
  output logic                                      o_data_val,
  input  logic                                      i_weight_req,
  output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_weight,
  output logic                                      o_weight_val,
  output logic                                      o_act_en,
  output logic [ADDR_WIDTH-1:0]                     o_act_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_act_rdata,
  output logic                                      o_wgt_en,
  output logic [ADDR_WIDTH-1:0]                     o_wgt_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_wgt_rdata,
  input  logic [REG_WIDTH-1:0]                      i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]                      i_conf_actbase,
  input  logic [REG_WIDTH-1:0]                      i_conf_numlines,
  input  logic [REG_WIDTH-1:0]                      i_conf_wgtbase,
  input  logic [REG_WIDTH-1:0]                      i_conf_wgtburst,
  input  logic [REG_WIDTH-1:0]                      i_conf_wgtsize,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_err
);

  typedef enum logic [1:0] {A_IDLE, A_RUN, A_DONE} act_state_t;
  typedef enum logic       {W_IDLE, W_BURST}       wgt_state_t;

  act_state_t            r_act_state;
  wgt_state_t            r_wgt_state;

  logic                  r_en_prev;
  logic                  r_wreq_prev;
  logic [ADDR_WIDTH-1:0] r_act_ptr;
  logic [15:0]           r_line_cnt;
  logic                  r_done_p0;
  logic                  r_act_vld_p1;
  logic [ADDR_WIDTH-1:0] r_wgt_off;
  logic [7:0]            r_burst_cnt;
  logic                  r_pending;
  logic                  r_wgt_vld_p1;

  logic                  w_en;
  logic                  w_en_rise;
  logic                  w_act_start;
  logic                  w_wgt_start;
  logic                  w_burst_last;
  logic [ADDR_WIDTH-1:0] w_wgt_addr;
  logic [ADDR_WIDTH-1:0] w_wgt_off_nxt;
  logic                  w_unused;

  assign w_en         = i_conf_ctrl[0];
  assign w_en_rise    = w_en & ~r_en_prev;
  assign w_act_start  = (r_act_state == A_IDLE) && w_en_rise;
  assign w_wgt_start  = i_weight_req & ~r_wreq_prev;
  assign w_burst_last = (r_burst_cnt == i_conf_wgtburst[7:0]);
  assign w_wgt_addr   = i_conf_wgtbase[ADDR_WIDTH-1:0] + r_wgt_off;
  // >= rather than == so a shrunk wgtsize still wraps instead of running away
  assign w_wgt_off_nxt = (r_wgt_off >= i_conf_wgtsize[ADDR_WIDTH-1:0]) ?
                         '0 : r_wgt_off + ADDR_WIDTH'(1);

  assign w_unused = ^{i_conf_ctrl[REG_WIDTH-1:1],
                      i_conf_actbase[REG_WIDTH-1:ADDR_WIDTH],
                      i_conf_numlines[REG_WIDTH-1:16],
                      i_conf_wgtbase[REG_WIDTH-1:ADDR_WIDTH],
                      i_conf_wgtburst[REG_WIDTH-1:8],
                      i_conf_wgtsize[REG_WIDTH-1:ADDR_WIDTH]};

  // Activation path: stage p0 issues the BRAM read, p1 carries the valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_state  <= A_IDLE;
      r_en_prev    <= 1'b0;
      r_act_ptr    <= '0;
      r_line_cnt   <= '0;
      r_done_p0    <= 1'b0;
      r_act_vld_p1 <= 1'b0;
      o_act_en     <= 1'b0;
      o_act_addr   <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_en_prev    <= w_en;
      o_act_en     <= 1'b0;
      r_done_p0    <= 1'b0;
      o_done       <= r_done_p0;
      r_act_vld_p1 <= o_act_en;
      case (r_act_state)
        A_IDLE: begin
          if (i_data_req) o_err <= 1'b1;
          if (w_en_rise) begin
            r_act_state <= A_RUN;
            r_act_ptr   <= i_conf_actbase[ADDR_WIDTH-1:0];
            r_line_cnt  <= '0;
          end
        end
        A_RUN: begin
          if (!w_en) begin
            r_act_state <= A_IDLE;
          end else if (i_data_req) begin
            o_act_en   <= 1'b1;
            o_act_addr <= r_act_ptr;
            r_act_ptr  <= r_act_ptr + ADDR_WIDTH'(1);
            if (i_data_end) begin
              r_line_cnt <= r_line_cnt + 16'd1;
              if (r_line_cnt == i_conf_numlines[15:0]) begin
                r_done_p0   <= 1'b1;
                r_act_state <= A_DONE;
              end
            end
          end
        end
        A_DONE: begin
          if (i_data_req) o_err <= 1'b1;
          if (!w_en) r_act_state <= A_IDLE;
        end
        default: r_act_state <= A_IDLE;
      endcase
    end
  end

  // Weight path: a start edge during a burst is remembered once and chains
  // straight into the next burst so the engine sees no refill gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wgt_state  <= W_IDLE;
      r_wreq_prev  <= 1'b0;
      r_wgt_off    <= '0;
      r_burst_cnt  <= '0;
      r_pending    <= 1'b0;
      r_wgt_vld_p1 <= 1'b0;
      o_wgt_en     <= 1'b0;
      o_wgt_addr   <= '0;
    end else begin
      r_wreq_prev  <= i_weight_req;
      o_wgt_en     <= 1'b0;
      r_wgt_vld_p1 <= o_wgt_en;
      if (!w_en) begin
        r_wgt_state <= W_IDLE;
        r_pending   <= 1'b0;
      end else begin
        case (r_wgt_state)
          W_IDLE: begin
            if (w_wgt_start) begin
              r_wgt_state <= W_BURST;
              r_burst_cnt <= '0;
            end
          end
          W_BURST: begin
            o_wgt_en   <= 1'b1;
            o_wgt_addr <= w_wgt_addr;
            r_wgt_off  <= w_wgt_off_nxt;
            if (w_burst_last) begin
              r_burst_cnt <= '0;
              if (r_pending || w_wgt_start) begin
                r_pending <= 1'b0;
              end else begin
                r_wgt_state <= W_IDLE;
              end
            end else begin
              r_burst_cnt <= r_burst_cnt + 8'd1;
              if (w_wgt_start) r_pending <= 1'b1;
            end
          end
          default: r_wgt_state <= W_IDLE;
        endcase
      end
      // A new activation run restarts the weight stream from its base
      if (w_act_start) r_wgt_off <= '0;
    end
  end

  assign o_data_val   = r_act_vld_p1;
  assign o_data       = r_act_vld_p1 ? i_act_rdata : '0;
  assign o_weight_val = r_wgt_vld_p1;
  assign o_weight     = r_wgt_vld_p1 ? i_wgt_rdata : '0;
  assign o_busy       = (r_act_state == A_RUN);

endmodule

// File: tb/tb_line_engine_feeder.sv
// Self-checking bench for line_engine_feeder: address/data scoreboards plus a
// per-cycle vector table for the activation line/done/error sequence.
module tb_line_engine_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_data_req, i_data_end, i_weight_req;
  logic [23:0] o_data, act_rdata;
  logic        o_data_val, o_weight_val;
  logic [95:0] o_weight, wgt_rdata;
  logic        o_act_en, o_wgt_en;
  logic [15:0] o_act_addr, o_wgt_addr;
  logic [31:0] conf_ctrl, conf_actbase, conf_numlines;
  logic [31:0] conf_wgtbase, conf_wgtburst, conf_wgtsize;
  logic        o_busy, o_done, o_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  line_engine_feeder dut (
    .clk(clk), .rst(rst),
    .i_data_req(i_data_req), .i_data_end(i_data_end),
    .o_data(o_data), .o_data_val(o_data_val),
    .i_weight_req(i_weight_req), .o_weight(o_weight), .o_weight_val(o_weight_val),
    .o_act_en(o_act_en), .o_act_addr(o_act_addr), .i_act_rdata(act_rdata),
    .o_wgt_en(o_wgt_en), .o_wgt_addr(o_wgt_addr), .i_wgt_rdata(wgt_rdata),
    .i_conf_ctrl(conf_ctrl), .i_conf_actbase(conf_actbase),
    .i_conf_numlines(conf_numlines), .i_conf_wgtbase(conf_wgtbase),
    .i_conf_wgtburst(conf_wgtburst), .i_conf_wgtsize(conf_wgtsize),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  function automatic logic [23:0] act_fn(input logic [15:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8], a[7:0] + 8'd3};
  endfunction

  function automatic logic [95:0] wgt_fn(input logic [15:0] a);
    return {a, ~a, a ^ 16'h1234, a + 16'd7, a - 16'd9, {a[7:0], a[15:8]}};
  endfunction

  // BRAM models with one-cycle read latency; junk when not enabled
  always @(posedge clk) begin
    act_rdata <= o_act_en ? act_fn(o_act_addr) : 24'($urandom);
    wgt_rdata <= o_wgt_en ? wgt_fn(o_wgt_addr) : {$urandom, $urandom, $urandom};
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  logic [15:0] act_q[$];
  logic [15:0] wgt_q[$];
  logic [23:0] dat_q[$];
  logic [95:0] wdat_q[$];
  logic        mon_on = 1'b0;
  logic        prev_aen = 1'b0, prev_wen = 1'b0;
  int          aen_cnt = 0, dval_cnt = 0, wen_cnt = 0, wval_cnt = 0;

  always @(negedge clk) begin : monitor
    logic [15:0] ea;
    if (mon_on && rst) begin
      if (o_act_en) begin
        if (act_q.size() == 0) chk("act_en_unexpected", o_act_en, 1'b0);
        else begin
          ea = act_q.pop_front();
          chk("act_addr", o_act_addr, ea);
          dat_q.push_back(act_fn(ea));
        end
      end
      if (o_data_val) begin
        if (dat_q.size() == 0) chk("data_val_unexpected", o_data_val, 1'b0);
        else chk("o_data", o_data, dat_q.pop_front());
      end
      if (o_data_val || prev_aen) chk("data_val_lag", o_data_val, prev_aen);
      if (o_wgt_en) begin
        if (wgt_q.size() == 0) chk("wgt_en_unexpected", o_wgt_en, 1'b0);
        else begin
          ea = wgt_q.pop_front();
          chk("wgt_addr", o_wgt_addr, ea);
          wdat_q.push_back(wgt_fn(ea));
        end
      end
      if (o_weight_val) begin
        if (wdat_q.size() == 0) chk("weight_val_unexpected", o_weight_val, 1'b0);
        else chk("o_weight", o_weight, wdat_q.pop_front());
      end
      if (o_weight_val || prev_wen) chk("weight_val_lag", o_weight_val, prev_wen);
    end
    prev_aen <= o_act_en;
    prev_wen <= o_wgt_en;
    aen_cnt  <= aen_cnt + int'(o_act_en);
    dval_cnt <= dval_cnt + int'(o_data_val);
    wen_cnt  <= wen_cnt + int'(o_wgt_en);
    wval_cnt <= wval_cnt + int'(o_weight_val);
  end

  typedef struct {
    logic req; logic dend; logic issue;
    logic busy; logic done; logic err;
  } vec_t;

  task automatic chk_all_zero(input string tag);
    chk({tag, "_act_en"}, o_act_en, 0);
    chk({tag, "_wgt_en"}, o_wgt_en, 0);
    chk({tag, "_data_val"}, o_data_val, 0);
    chk({tag, "_weight_val"}, o_weight_val, 0);
    chk({tag, "_act_addr"}, o_act_addr, 0);
    chk({tag, "_wgt_addr"}, o_wgt_addr, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_weight"}, o_weight, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    vec_t        tbl[10];
    logic [15:0] exp_aptr;
    logic [13:0] pat;
    int          a0, d0, w0, v0, run, maxrun, both;

    tbl[0] = '{1, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 1, 1, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 1, 1, 0, 0};
    tbl[4] = '{1, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 1};
    tbl[8] = '{0, 0, 0, 0, 0, 1};
    tbl[9] = '{1, 1, 0, 0, 0, 1};

    rst = 1'b0;
    i_data_req = 0; i_data_end = 0; i_weight_req = 0;
    conf_ctrl = 0; conf_actbase = 0; conf_numlines = 0;
    conf_wgtbase = 32'h40; conf_wgtburst = 32'd7; conf_wgtsize = 32'd4;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b1;

    // Reset in the middle of a weight burst
    @(posedge clk); #1;
    conf_ctrl = 1; i_weight_req = 1;
    repeat (5) @(posedge clk);
    #1 chk("midburst_wgt_en", o_wgt_en, 1);
    chk("midburst_busy", o_busy, 1);
    rst = 1'b0;
    #1 chk_all_zero("async_reset");
    i_weight_req = 0; conf_ctrl = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    d0 = dval_cnt; v0 = wval_cnt;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_reset_data_vals", dval_cnt - d0, 0);
    chk("post_reset_weight_vals", wval_cnt - v0, 0);

    // Activation lines, completion and request-in-DONE error
    mon_on = 1'b1;
    @(posedge clk); #1;
    conf_actbase = 32'h100; conf_numlines = 32'd1; conf_ctrl = 1;
    @(posedge clk); #1;
    chk("act_run_busy", o_busy, 1);
    exp_aptr = 16'h100;
    for (int i = 0; i < 10; i++) begin
      i_data_req = tbl[i].req; i_data_end = tbl[i].dend;
      if (tbl[i].issue) begin
        act_q.push_back(exp_aptr);
        exp_aptr = exp_aptr + 16'd1;
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), o_done, tbl[i].done);
      chk($sformatf("vec%0d_err", i), o_err, tbl[i].err);
    end
    i_data_req = 0; i_data_end = 0; conf_ctrl = 0;
    repeat (2) @(posedge clk);
    #1 chk("err_sticky", o_err, 1);
    chk("idle_after_disable", o_busy, 0);
    rst = 1'b0;
    #1 chk("err_cleared_by_reset", o_err, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Weight bursts with offset wrap
    conf_actbase = 32'h200; conf_numlines = 32'hFFFF;
    conf_wgtbase = 32'h40; conf_wgtburst = 32'd2; conf_wgtsize = 32'd4;
    @(posedge clk); #1 conf_ctrl = 1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 3; k++) wgt_q.push_back(16'h40 + 16'((b * 3 + k) % 5));
      @(negedge clk);
      w0 = wen_cnt; v0 = wval_cnt;
      @(posedge clk); #1 i_weight_req = 1;
      @(posedge clk); #1 i_weight_req = 0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk($sformatf("burst%0d_en_count", b), wen_cnt - w0, 3);
      chk($sformatf("burst%0d_val_count", b), wval_cnt - v0, 3);
    end

    // Second start edge one cycle into a burst chains without a gap
    for (int k = 0; k < 6; k++) wgt_q.push_back(16'h40 + 16'((1 + k) % 5));
    w0 = wen_cnt; run = 0; maxrun = 0;
    pat = 14'b00000000000101;
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      i_weight_req = pat[c];
      @(negedge clk);
      if (o_wgt_en) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("chained_burst_run", maxrun, 6);
    chk("chained_burst_en_count", wen_cnt - w0, 6);

    // Data and weight ports busy together
    conf_wgtburst = 32'd7;
    for (int k = 0; k < 8; k++) wgt_q.push_back(16'h40 + 16'((2 + k) % 5));
    a0 = aen_cnt; d0 = dval_cnt; w0 = wen_cnt; v0 = wval_cnt; both = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      i_data_req = (c < 8); i_weight_req = (c < 8);
      if (c < 8) act_q.push_back(16'h200 + 16'(c));
      @(negedge clk);
      if (o_act_en && o_wgt_en) both++;
      @(posedge clk); #1;
    end
    i_data_req = 0; i_weight_req = 0;
    @(negedge clk);
    chk("dual_act_en_count", aen_cnt - a0, 8);
    chk("dual_data_val_count", dval_cnt - d0, 8);
    chk("dual_wgt_en_count", wen_cnt - w0, 8);
    chk("dual_weight_val_count", wval_cnt - v0, 8);
    chk("dual_overlap_cycles", both, 7);
    chk("act_queue_drained", act_q.size() + dat_q.size(), 0);
    chk("wgt_queue_drained", wgt_q.size() + wdat_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
